// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq -- sequential binary-to-BCD converter (shift-add-3 / double dabble).
// One iteration per clock. A conversion takes WIDTH cycles in SHIFT, then one
// cycle in DONE with done high and the result on bcd.
//
// Parameters
//   WIDTH  : binary operand width (>= 2)
//   DIGITS : BCD digits on bcd; 10**DIGITS must exceed 2**WIDTH - 1
// Ports
//   clk   : clock, all state changes on rising edge
//   rst   : synchronous active-high reset
//   start : conversion request, accepted only while busy = 0
//   bin   : unsigned operand, captured when start is accepted
//   busy  : high while SHIFT iterations are running
//   done  : one-cycle pulse, bcd carries a new result in that cycle
//   bcd   : packed BCD result, digit i in bits [4i+3:4i]; held between results
module bin2bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state;
  logic [BW-1:0]     scr;    // scratch BCD accumulator, never visible on bcd
  logic [WIDTH-1:0]  opnd;   // operand, shifted out MSB first into scr
  logic [CW-1:0]     cnt;    // iterations completed in this conversion
  logic [BW-1:0]     adj;    // scr after the per-digit add-3 correction
  logic [BW+WIDTH-1:0] sh_nxt;
  logic              last;

  // Per-digit correction: any digit >= 5 gets +3 so the following shift
  // carries correctly into the next decimal digit.
  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    assign adj[4*i +: 4] = (scr[4*i +: 4] >= 4'd5) ? scr[4*i +: 4] + 4'd3
                                                    : scr[4*i +: 4];
  end

  // Shift {scratch, operand} as one vector; the bit dropped off the top is
  // always zero given the DIGITS sizing guarantee.
  assign sh_nxt = {adj, opnd} << 1;
  assign last   = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      bcd   <= '0;
      scr   <= '0;
      opnd  <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            state <= SHIFT;
            busy  <= 1'b1;
            opnd  <= bin;
            scr   <= '0;
            cnt   <= '0;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          scr  <= sh_nxt[BW+WIDTH-1:WIDTH];
          opnd <= sh_nxt[WIDTH-1:0];
          cnt  <= cnt + CW'(1);
          // Final iteration: publish the freshly shifted scratch value so the
          // result lands on bcd on the same edge that enters DONE.
          if (last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            bcd   <= sh_nxt[BW+WIDTH-1:WIDTH];
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq. Main instance WIDTH=8/DIGITS=3, second
// instance WIDTH=4/DIGITS=2. Expected BCD comes from a decimal-digit model.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        start4 = 1'b0;
  logic [7:0]  bin = '0;
  logic [3:0]  bin4 = '0;
  logic        busy, done, busy4, done4;
  logic [11:0] bcd;
  logic [7:0]  bcd4;

  int          total = 0;
  int          bad = 0;
  logic [11:0] exp_bcd = '0;

  bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .busy(busy), .done(done), .bcd(bcd)
  );

  bin2bcd_seq #(.WIDTH(4), .DIGITS(2)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .bin(bin4),
    .busy(busy4), .done(done4), .bcd(bcd4)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  // Reference: decimal digits by repeated division.
  function automatic logic [31:0] dec2bcd(input int v);
    logic [31:0] r;
    int          x;
    r = '0;
    x = v;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full conversion on the 8-bit instance; bin is scrambled during SHIFT and
  // the old result must stay on bcd until the final edge.
  task automatic conv(input logic [7:0] v);
    logic [31:0] e;
    start = 1'b1;
    bin   = v;
    tick();
    chk("acc_busy", 32'(busy), 1);
    chk("acc_done", 32'(done), 0);
    start = 1'b0;
    for (int c = 1; c < 8; c++) begin
      bin = 8'($urandom);
      tick();
      chk("run_busy", 32'(busy), 1);
      chk("run_done", 32'(done), 0);
      chk("run_hold", 32'(bcd), 32'(exp_bcd));
    end
    tick();
    e = dec2bcd(int'(v));
    exp_bcd = e[11:0];
    chk("fin_busy", 32'(busy), 0);
    chk("fin_done", 32'(done), 1);
    chk("fin_bcd", 32'(bcd), 32'(exp_bcd));
    tick();
    chk("post_done", 32'(done), 0);
    chk("post_busy", 32'(busy), 0);
    chk("post_bcd", 32'(bcd), 32'(exp_bcd));
  endtask

  initial begin
    logic [31:0] e;

    // Reset
    rst = 1'b1;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_bcd", 32'(bcd), 0);
    chk("rst_bcd4", 32'(bcd4), 0);

    // Reset beats start on the same edge
    start = 1'b1;
    bin   = 8'd55;
    tick();
    chk("rst_vs_start", 32'(busy), 0);
    rst   = 1'b0;
    start = 1'b0;
    tick();
    chk("rst_vs_start_idle", 32'(busy), 0);

    // Directed values: max, zero, two digits, unused high digits
    conv(8'd255);
    conv(8'd0);
    conv(8'd99);
    conv(8'd7);

    // Start re-pulsed in the 3rd busy cycle is ignored
    start = 1'b1;
    bin   = 8'd200;
    tick();
    start = 1'b0;
    tick();
    tick();
    start = 1'b1;
    bin   = 8'd1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("ign_done", 32'(done), (i == 4) ? 1 : 0);
    end
    exp_bcd = 12'h200;
    chk("ign_bcd", 32'(bcd), 32'(exp_bcd));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ign_quiet", 32'(done | busy), 0);
    end

    // Reset in the 4th busy cycle aborts
    start = 1'b1;
    bin   = 8'd123;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_bcd = '0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_bcd", 32'(bcd), 0);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("abort_nodone", 32'(done), 0);
    end

    // Random conversions
    for (int n = 0; n < 20; n++) conv(8'($urandom_range(0, 255)));

    // start held high: one result every 9 cycles
    start = 1'b1;
    for (int n = 0; n < 256; n++) begin
      bin = 8'(n);
      tick();
      for (int j = 1; j <= 8; j++) begin
        bin = 8'($urandom);
        tick();
        chk("b2b_done", 32'(done), (j == 8) ? 1 : 0);
        chk("b2b_busy", 32'(busy), (j == 8) ? 0 : 1);
      end
      e = dec2bcd(n);
      chk("b2b_bcd", 32'(bcd), 32'(e[11:0]));
    end
    start = 1'b0;
    tick();
    chk("b2b_end_done", 32'(done), 0);
    chk("b2b_end_busy", 32'(busy), 0);

    // 4-bit instance, exhaustive, start held high
    start4 = 1'b1;
    for (int n = 0; n < 16; n++) begin
      bin4 = 4'(n);
      tick();
      for (int j = 1; j <= 4; j++) begin
        bin4 = 4'($urandom);
        tick();
        chk("w4_done", 32'(done4), (j == 4) ? 1 : 0);
        chk("w4_busy", 32'(busy4), (j == 4) ? 0 : 1);
      end
      e = dec2bcd(n);
      chk("w4_bcd", 32'(bcd4), 32'(e[7:0]));
    end
    start4 = 1'b0;
    tick();
    chk("w4_end_done", 32'(done4), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
